// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: instruction class
// codes, exception bit positions, FSM states and small decode helpers.
package mem_stage_lsu_pkg;

  localparam int EXC_W = 32;

  localparam logic [7:0] INST_T_NOP = 8'h00;
  localparam logic [7:0] INST_T_LB  = 8'h01;
  localparam logic [7:0] INST_T_LBU = 8'h02;
  localparam logic [7:0] INST_T_LH  = 8'h03;
  localparam logic [7:0] INST_T_LHU = 8'h04;
  localparam logic [7:0] INST_T_LW  = 8'h05;
  localparam logic [7:0] INST_T_SB  = 8'h06;
  localparam logic [7:0] INST_T_SH  = 8'h07;
  localparam logic [7:0] INST_T_SW  = 8'h08;
  localparam logic [7:0] INST_T_LL  = 8'h09;
  localparam logic [7:0] INST_T_SC  = 8'h0A;

  // Bit positions inside the exception vector handed to CP0
  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [7:0] t);
    return (t == INST_T_LB) || (t == INST_T_LBU) || (t == INST_T_LH) ||
           (t == INST_T_LHU) || (t == INST_T_LW) || (t == INST_T_LL);
  endfunction

  function automatic logic is_store(input logic [7:0] t);
    return (t == INST_T_SB) || (t == INST_T_SH) || (t == INST_T_SW) || (t == INST_T_SC);
  endfunction

  function automatic logic is_half_access(input logic [7:0] t);
    return (t == INST_T_LH) || (t == INST_T_LHU) || (t == INST_T_SH);
  endfunction

  function automatic logic is_word_access(input logic [7:0] t);
    return (t == INST_T_LW) || (t == INST_T_SW) || (t == INST_T_LL) || (t == INST_T_SC);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data bus between the MEM stage (master) and the data memory (slave).
// Single outstanding request, completed by a one-cycle ack.
interface mem_stage_lsu_if #(
  parameter int DW = 32
);
  logic          dbus_req;
  logic          dbus_we;
  logic [DW-1:0] dbus_addr;
  logic [3:0]    dbus_sel;
  logic [DW-1:0] dbus_wdata;
  logic [DW-1:0] dbus_rdata;
  logic          dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Big-endian byte-lane steering for stores and byte/half extraction with
// sign or zero extension for loads. Purely combinational.
module lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [7:0]  i_inst_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte enables and replicated write data; offset 0 is the most significant lane
  always_comb begin
    o_sel   = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_inst_type)
      INST_T_SB: begin
        o_sel   = 4'b1000 >> i_offset;
        o_wdata = {4{i_store_data[7:0]}};
      end
      INST_T_SH: begin
        o_sel   = i_offset[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_store_data[15:0]}};
      end
      INST_T_SW, INST_T_SC: begin
        o_sel   = 4'b1111;
        o_wdata = i_store_data;
      end
      INST_T_LB, INST_T_LBU, INST_T_LH, INST_T_LHU, INST_T_LW, INST_T_LL: begin
        o_sel   = 4'b1111;
      end
      default: begin
        o_sel   = 4'b0000;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    o_load_data = 32'h0000_0000;
    case (i_offset)
      2'd0:    w_byte = i_load_word[31:24];
      2'd1:    w_byte = i_load_word[23:16];
      2'd2:    w_byte = i_load_word[15:8];
      default: w_byte = i_load_word[7:0];
    endcase
    w_half = i_offset[1] ? i_load_word[15:0] : i_load_word[31:16];
    case (i_inst_type)
      INST_T_LB:            o_load_data = {{24{w_byte[7]}}, w_byte};
      INST_T_LBU:           o_load_data = {24'h000000, w_byte};
      INST_T_LH:            o_load_data = {{16{w_half[15]}}, w_half};
      INST_T_LHU:           o_load_data = {16'h0000, w_half};
      INST_T_LW, INST_T_LL: o_load_data = i_load_word;
      default:              o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the 5-stage core. Issues loads/stores on the data
// bus, stalls IF..MEM while an access is outstanding, owns the LL/SC link bit
// and raises address-error exceptions for misaligned accesses.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_mem_gpr_we,
  input  logic [4:0]       i_mem_target_gpr,
  input  logic [DW-1:0]    i_mem_exe_result,
  input  logic [DW-1:0]    i_mem_hi,
  input  logic [DW-1:0]    i_mem_lo,
  input  logic             i_mem_hilo_we,
  input  logic [7:0]       i_mem_inst_type,
  input  logic [DW-1:0]    i_mem_dmem_addr,
  input  logic [DW-1:0]    i_mem_ls_data_tmp,
  input  logic             i_mem_cp0_we,
  input  logic [4:0]       i_mem_cp0_waddr,
  input  logic [DW-1:0]    i_mem_cp0_wdata,
  input  logic [EXC_W-1:0] i_mem_except_type,
  input  logic [DW-1:0]    i_mem_cur_inst_addr,
  input  logic             i_mem_inst_delayslot,
  output logic             o_wb_gpr_we,
  output logic [4:0]       o_wb_target_gpr,
  output logic [DW-1:0]    o_wb_gpr_wdata,
  output logic [DW-1:0]    o_wb_hi,
  output logic [DW-1:0]    o_wb_lo,
  output logic             o_wb_hilo_we,
  output logic             o_wb_cp0_we,
  output logic [4:0]       o_wb_cp0_waddr,
  output logic [DW-1:0]    o_wb_cp0_wdata,
  output logic [EXC_W-1:0] o_except_type,
  output logic [DW-1:0]    o_cur_inst_addr,
  output logic             o_inst_delayslot,
  output logic [DW-1:0]    o_bad_vaddr,
  output logic             o_stall_req,
  mem_stage_lsu_if.master  dbus
);

  lsu_state_e       r_state;
  lsu_state_e       w_next_state;
  logic             r_llbit;
  logic [DW-1:0]    r_rdata_q;
  logic             r_bus_we;
  logic [DW-1:0]    r_bus_addr;
  logic [3:0]       r_bus_sel;
  logic [DW-1:0]    r_bus_wdata;

  logic [1:0]       w_offset;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_misalign;
  logic             w_sc_fail;
  logic             w_acc_v;
  logic             w_has_exc;
  logic [EXC_W-1:0] w_except;
  logic [DW-1:0]    w_word_addr;
  logic [3:0]       w_sel;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_load_data;
  logic             w_bus_req;
  logic             w_bus_live;
  logic             w_stall;
  logic             w_capture;
  logic             w_latch;

  lsu_lane_align u_lane_align (
    .i_inst_type  (i_mem_inst_type),
    .i_offset     (w_offset),
    .i_store_data (i_mem_ls_data_tmp),
    .i_load_word  (r_rdata_q),
    .o_sel        (w_sel),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // Classify the instruction, fold in alignment errors and decide whether an access may start
  always_comb begin
    w_offset    = i_mem_dmem_addr[1:0];
    w_is_load   = is_load(i_mem_inst_type);
    w_is_store  = is_store(i_mem_inst_type);
    w_misalign  = (is_half_access(i_mem_inst_type) && w_offset[0]) ||
                  (is_word_access(i_mem_inst_type) && (w_offset != 2'b00));
    w_except    = i_mem_except_type;
    if (w_misalign && w_is_load)  w_except[EXC_ADEL] = 1'b1;
    if (w_misalign && w_is_store) w_except[EXC_ADES] = 1'b1;
    w_has_exc   = (w_except != '0);
    w_sc_fail   = (i_mem_inst_type == INST_T_SC) && !r_llbit;
    w_acc_v     = (w_is_load || w_is_store) && (i_mem_except_type == '0) &&
                  !w_misalign && !w_sc_fail;
    w_word_addr = {i_mem_dmem_addr[DW-1:2], 2'b00};
  end

  // Access FSM next state and control: a flushed access is drained so the bus still sees its ack
  always_comb begin
    w_next_state = r_state;
    w_bus_req    = 1'b0;
    w_bus_live   = 1'b0;
    w_stall      = 1'b0;
    w_capture    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_v && !i_flush) begin
          w_bus_req  = 1'b1;
          w_bus_live = 1'b1;
          w_stall    = 1'b1;
          if (dbus.dbus_ack) begin
            w_capture    = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_latch      = 1'b1;
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_bus_req = 1'b1;
        w_stall   = 1'b1;
        if (dbus.dbus_ack) begin
          if (i_flush) begin
            w_next_state = ST_IDLE;
          end else begin
            w_capture    = 1'b1;
            w_next_state = ST_DONE;
          end
        end else if (i_flush) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_bus_req = 1'b1;
        w_stall   = 1'b1;
        if (dbus.dbus_ack) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Hold the bus fields while waiting and capture read data on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= 4'b0000;
      r_bus_wdata <= '0;
      r_rdata_q   <= '0;
    end else begin
      if (w_latch) begin
        r_bus_we    <= w_is_store;
        r_bus_addr  <= w_word_addr;
        r_bus_sel   <= w_sel;
        r_bus_wdata <= w_wdata;
      end
      if (w_capture) begin
        r_rdata_q <= dbus.dbus_rdata;
      end
    end
  end

  // LL/SC link bit; a flush always wins over an LL completing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_llbit <= 1'b0;
    end else if (i_flush) begin
      r_llbit <= 1'b0;
    end else if ((r_state == ST_DONE) && (i_mem_inst_type == INST_T_LL)) begin
      r_llbit <= 1'b1;
    end else if ((r_state == ST_DONE) && (i_mem_inst_type == INST_T_SC)) begin
      r_llbit <= 1'b0;
    end
  end

  // Bus drive: live fields on the issue cycle, latched fields afterwards, quiet otherwise
  always_comb begin
    dbus.dbus_req   = 1'b0;
    dbus.dbus_we    = 1'b0;
    dbus.dbus_addr  = '0;
    dbus.dbus_sel   = 4'b0000;
    dbus.dbus_wdata = '0;
    o_stall_req     = w_stall && !rst;
    if (w_bus_req && !rst) begin
      dbus.dbus_req = 1'b1;
      if (w_bus_live) begin
        dbus.dbus_we    = w_is_store;
        dbus.dbus_addr  = w_word_addr;
        dbus.dbus_sel   = w_sel;
        dbus.dbus_wdata = w_wdata;
      end else begin
        dbus.dbus_we    = r_bus_we;
        dbus.dbus_addr  = r_bus_addr;
        dbus.dbus_sel   = r_bus_sel;
        dbus.dbus_wdata = r_bus_wdata;
      end
    end
  end

  // Writeback and exception outputs; everything to MEM/WB is killed by an exception or a drain
  always_comb begin
    o_wb_gpr_we     = i_mem_gpr_we;
    o_wb_target_gpr = i_mem_target_gpr;
    o_wb_gpr_wdata  = i_mem_exe_result;
    o_wb_hi         = i_mem_hi;
    o_wb_lo         = i_mem_lo;
    o_wb_hilo_we    = i_mem_hilo_we;
    o_wb_cp0_we     = i_mem_cp0_we;
    o_wb_cp0_waddr  = i_mem_cp0_waddr;
    o_wb_cp0_wdata  = i_mem_cp0_wdata;
    if (w_is_load) begin
      o_wb_gpr_wdata = w_load_data;
    end else if (i_mem_inst_type == INST_T_SC) begin
      o_wb_gpr_wdata = {{(DW-1){1'b0}}, (r_state == ST_DONE)};
    end
    if (w_has_exc || (r_state == ST_DRAIN)) begin
      o_wb_gpr_we     = 1'b0;
      o_wb_target_gpr = 5'd0;
      o_wb_gpr_wdata  = '0;
      o_wb_hi         = '0;
      o_wb_lo         = '0;
      o_wb_hilo_we    = 1'b0;
      o_wb_cp0_we     = 1'b0;
      o_wb_cp0_waddr  = 5'd0;
      o_wb_cp0_wdata  = '0;
    end
    o_except_type    = w_except;
    o_cur_inst_addr  = i_mem_cur_inst_addr;
    o_inst_delayslot = i_mem_inst_delayslot;
    o_bad_vaddr      = i_mem_dmem_addr;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by
// randomized instructions, all checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush, gprWe, hiloWe, cp0We, delaySlot;
  logic [4:0]  targetGpr, cp0Waddr;
  logic [7:0]  instType;
  logic [31:0] exeResult, hiIn, loIn, dmemAddr, lsData, cp0Wdata, exceptIn, curInstAddr;

  logic        wbGprWe, wbHiloWe, wbCp0We, delaySlotOut, stallReq;
  logic [4:0]  wbTargetGpr, wbCp0Waddr;
  logic [31:0] wbGprWdata, wbHi, wbLo, wbCp0Wdata, exceptOut, curInstAddrOut, badVaddr;

  mem_stage_lsu_if #(.DW(32)) dbusIf ();

  mem_stage_lsu #(.DW(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_flush              (flush),
    .i_mem_gpr_we         (gprWe),
    .i_mem_target_gpr     (targetGpr),
    .i_mem_exe_result     (exeResult),
    .i_mem_hi             (hiIn),
    .i_mem_lo             (loIn),
    .i_mem_hilo_we        (hiloWe),
    .i_mem_inst_type      (instType),
    .i_mem_dmem_addr      (dmemAddr),
    .i_mem_ls_data_tmp    (lsData),
    .i_mem_cp0_we         (cp0We),
    .i_mem_cp0_waddr      (cp0Waddr),
    .i_mem_cp0_wdata      (cp0Wdata),
    .i_mem_except_type    (exceptIn),
    .i_mem_cur_inst_addr  (curInstAddr),
    .i_mem_inst_delayslot (delaySlot),
    .o_wb_gpr_we          (wbGprWe),
    .o_wb_target_gpr      (wbTargetGpr),
    .o_wb_gpr_wdata       (wbGprWdata),
    .o_wb_hi              (wbHi),
    .o_wb_lo              (wbLo),
    .o_wb_hilo_we         (wbHiloWe),
    .o_wb_cp0_we          (wbCp0We),
    .o_wb_cp0_waddr       (wbCp0Waddr),
    .o_wb_cp0_wdata       (wbCp0Wdata),
    .o_except_type        (exceptOut),
    .o_cur_inst_addr      (curInstAddrOut),
    .o_inst_delayslot     (delaySlotOut),
    .o_bad_vaddr          (badVaddr),
    .o_stall_req          (stallReq),
    .dbus                 (dbusIf)
  );

  int   compared   = 0;
  int   mismatched = 0;
  bit   modelLl    = 1'b0;
  logic [7:0] codeList [0:10];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setNop();
    instType  = INST_T_NOP;
    gprWe     = 1'b0;
    hiloWe    = 1'b0;
    cp0We     = 1'b0;
    exceptIn  = 32'h0;
    dmemAddr  = $urandom;
    exeResult = $urandom;
  endtask

  task automatic flushCycle(input string name);
    setNop();
    flush = 1'b1;
    @(negedge clk);
    checkOutput({name, ".req"}, {31'h0, dbusIf.dbus_req}, 32'h0);
    checkOutput({name, ".stall"}, {31'h0, stallReq}, 32'h0);
    nextCycle();
    flush   = 1'b0;
    modelLl = 1'b0;
  endtask

  // One instruction through MEM; flushAt = 0 flushes in the issue cycle, > 0 flushes while waiting
  task automatic applyStimulus(input string name, input logic [7:0] t, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [31:0] exc, input int waits,
                               input logic [31:0] word, input int flushAt);
    bit          isLoad, isStore, misalign, hasExc, access;
    int          o;
    logic [31:0] expExc, expWdata, expResult, expAddr, part;
    logic [3:0]  expSel;
    o        = int'(addr % 4);
    isLoad   = (t == INST_T_LB) || (t == INST_T_LBU) || (t == INST_T_LH) ||
               (t == INST_T_LHU) || (t == INST_T_LW) || (t == INST_T_LL);
    isStore  = (t == INST_T_SB) || (t == INST_T_SH) || (t == INST_T_SW) || (t == INST_T_SC);
    misalign = ((t == INST_T_LH || t == INST_T_LHU || t == INST_T_SH) && (addr % 2 != 0)) ||
               ((t == INST_T_LW || t == INST_T_SW || t == INST_T_LL || t == INST_T_SC) && (o != 0));
    expExc = exc;
    if (misalign && isLoad)  expExc[EXC_ADEL] = 1'b1;
    if (misalign && isStore) expExc[EXC_ADES] = 1'b1;
    hasExc  = (expExc != 0);
    access  = (isLoad || isStore) && !hasExc && !(t == INST_T_SC && !modelLl) && (flushAt != 0);
    expAddr = addr - o;
    expSel  = 4'hF;
    expWdata = 32'h0;
    if (t == INST_T_SB) begin
      expSel   = 4'(1 << (3 - o));
      expWdata = {24'h0, rt[7:0]} * 32'h0101_0101;
    end else if (t == INST_T_SH) begin
      expSel   = (o < 2) ? 4'hC : 4'h3;
      expWdata = {16'h0, rt[15:0]} * 32'h0001_0001;
    end else if (t == INST_T_SW || t == INST_T_SC) begin
      expWdata = rt;
    end

    instType    = t;
    dmemAddr    = addr;
    lsData      = rt;
    exceptIn    = exc;
    gprWe       = 1'b1;
    targetGpr   = 5'($urandom);
    exeResult   = $urandom;
    hiIn        = $urandom;
    loIn        = $urandom;
    hiloWe      = 1'($urandom);
    cp0We       = 1'($urandom);
    cp0Waddr    = 5'($urandom);
    cp0Wdata    = $urandom;
    curInstAddr = $urandom;
    delaySlot   = 1'($urandom);
    flush       = (flushAt == 0);
    dbusIf.dbus_ack   = 1'b0;
    dbusIf.dbus_rdata = $urandom;

    if (t == INST_T_LB || t == INST_T_LBU) begin
      part = (word >> (8 * (3 - o))) & 32'hFF;
      expResult = (t == INST_T_LB && part[7]) ? (part | 32'hFFFF_FF00) : part;
    end else if (t == INST_T_LH || t == INST_T_LHU) begin
      part = (word >> (16 * (1 - o / 2))) & 32'hFFFF;
      expResult = (t == INST_T_LH && part[15]) ? (part | 32'hFFFF_0000) : part;
    end else if (t == INST_T_LW || t == INST_T_LL) begin
      expResult = word;
    end else if (t == INST_T_SC) begin
      expResult = 32'h1;
    end else begin
      expResult = exeResult;
    end

    if (!access) begin
      @(negedge clk);
      checkOutput({name, ".req"}, {31'h0, dbusIf.dbus_req}, 32'h0);
      checkOutput({name, ".stall"}, {31'h0, stallReq}, 32'h0);
      checkOutput({name, ".except"}, exceptOut, expExc);
      checkOutput({name, ".badvaddr"}, badVaddr, addr);
      checkOutput({name, ".gprWe"}, {31'h0, wbGprWe}, hasExc ? 32'h0 : 32'h1);
      checkOutput({name, ".hiloWe"}, {31'h0, wbHiloWe}, hasExc ? 32'h0 : {31'h0, hiloWe});
      checkOutput({name, ".cp0Wdata"}, wbCp0Wdata, hasExc ? 32'h0 : cp0Wdata);
      if (!isLoad) begin
        checkOutput({name, ".gprWdata"}, wbGprWdata,
                    (hasExc || t == INST_T_SC) ? 32'h0 : exeResult);
      end
      if (flushAt == 0) modelLl = 1'b0;
      nextCycle();
      flush = 1'b0;
    end else begin
      for (int k = 0; k <= waits; k++) begin
        flush = (flushAt > 0) && (k == flushAt);
        if (flushAt > 0 && k == flushAt + 1) setNop();
        dbusIf.dbus_ack   = (k == waits);
        dbusIf.dbus_rdata = (k == waits) ? word : $urandom;
        @(negedge clk);
        checkOutput({name, ".req"}, {31'h0, dbusIf.dbus_req}, 32'h1);
        checkOutput({name, ".stall"}, {31'h0, stallReq}, 32'h1);
        checkOutput({name, ".we"}, {31'h0, dbusIf.dbus_we}, {31'h0, isStore});
        checkOutput({name, ".addr"}, dbusIf.dbus_addr, expAddr);
        checkOutput({name, ".sel"}, {28'h0, dbusIf.dbus_sel}, {28'h0, expSel});
        checkOutput({name, ".wdata"}, dbusIf.dbus_wdata, expWdata);
        nextCycle();
      end
      flush             = 1'b0;
      dbusIf.dbus_ack   = 1'b0;
      dbusIf.dbus_rdata = $urandom;
      if (flushAt > 0) begin
        if (waits == flushAt + 0) setNop();
        @(negedge clk);
        checkOutput({name, ".drainReq"}, {31'h0, dbusIf.dbus_req}, 32'h0);
        checkOutput({name, ".drainStall"}, {31'h0, stallReq}, 32'h0);
        checkOutput({name, ".drainGprWe"}, {31'h0, wbGprWe}, 32'h0);
        modelLl = 1'b0;
        nextCycle();
      end else begin
        @(negedge clk);
        checkOutput({name, ".doneReq"}, {31'h0, dbusIf.dbus_req}, 32'h0);
        checkOutput({name, ".doneStall"}, {31'h0, stallReq}, 32'h0);
        checkOutput({name, ".doneGprWe"}, {31'h0, wbGprWe}, 32'h1);
        if (isLoad || t == INST_T_SC) checkOutput({name, ".result"}, wbGprWdata, expResult);
        if (t == INST_T_LL) modelLl = 1'b1;
        if (t == INST_T_SC) modelLl = 1'b0;
        nextCycle();
      end
    end
  endtask

  initial begin
    logic [7:0]  t;
    logic [31:0] a, e;
    int          w, f, r, pick;
    codeList = '{INST_T_NOP, INST_T_LB, INST_T_LBU, INST_T_LH, INST_T_LHU, INST_T_LW,
                 INST_T_SB, INST_T_SH, INST_T_SW, INST_T_LL, INST_T_SC};
    rst = 1'b1;
    flush = 1'b0;
    setNop();
    lsData = 0; targetGpr = 0; hiIn = 0; loIn = 0; cp0Waddr = 0; cp0Wdata = 0;
    curInstAddr = 0; delaySlot = 0;
    dbusIf.dbus_ack = 1'b0;
    dbusIf.dbus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.req", {31'h0, dbusIf.dbus_req}, 32'h0);
    checkOutput("reset.we", {31'h0, dbusIf.dbus_we}, 32'h0);
    checkOutput("reset.addr", dbusIf.dbus_addr, 32'h0);
    checkOutput("reset.sel", {28'h0, dbusIf.dbus_sel}, 32'h0);
    checkOutput("reset.wdata", dbusIf.dbus_wdata, 32'h0);
    checkOutput("reset.stall", {31'h0, stallReq}, 32'h0);
    nextCycle();

    $display("[TB] directed scenarios");
    applyStimulus("lb", INST_T_LB, 32'h0000_1003, 32'h0, 32'h0, 2, 32'h1122_33F4, -1);
    applyStimulus("sh", INST_T_SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 32'h0, -1);
    applyStimulus("lwMis", INST_T_LW, 32'h0000_3001, 32'h0, 32'h0, 0, 32'h0, -1);
    applyStimulus("ll", INST_T_LL, 32'h0000_4000, 32'h0, 32'h0, 1, 32'hCAFE_F00D, -1);
    applyStimulus("sc1", INST_T_SC, 32'h0000_4000, 32'h1234_5678, 32'h0, 0, 32'h0, -1);
    applyStimulus("sc2", INST_T_SC, 32'h0000_4000, 32'h1234_5678, 32'h0, 0, 32'h0, -1);
    applyStimulus("ll2", INST_T_LL, 32'h0000_4100, 32'h0, 32'h0, 0, 32'h0BAD_BEEF, -1);
    flushCycle("llFlush");
    applyStimulus("scAfterFlush", INST_T_SC, 32'h0000_4100, 32'h55AA_55AA, 32'h0, 0, 32'h0, -1);
    applyStimulus("swDrain", INST_T_SW, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 4, 32'h0, 2);

    instType = INST_T_LW; dmemAddr = 32'h0000_6000; exceptIn = 32'h0; gprWe = 1'b1;
    dbusIf.dbus_ack = 1'b0;
    @(negedge clk);
    checkOutput("rstMid.issue", {31'h0, dbusIf.dbus_req}, 32'h1);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMid.reqInRst", {31'h0, dbusIf.dbus_req}, 32'h0);
    checkOutput("rstMid.stallInRst", {31'h0, stallReq}, 32'h0);
    nextCycle();
    rst = 1'b0;
    setNop();
    @(negedge clk);
    checkOutput("rstMid.reqAfter", {31'h0, dbusIf.dbus_req}, 32'h0);
    checkOutput("rstMid.stallAfter", {31'h0, stallReq}, 32'h0);
    modelLl = 1'b0;
    nextCycle();

    $display("[TB] randomized instructions");
    for (int i = 0; i < 120; i++) begin
      pick = $urandom_range(0, 15);
      if (pick <= 10)      t = codeList[pick];
      else if (pick <= 12) t = INST_T_LL;
      else if (pick <= 14) t = INST_T_SC;
      else                 t = INST_T_NOP;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (t == INST_T_LW || t == INST_T_SW || t == INST_T_LL || t == INST_T_SC) a[1:0] = 2'b00;
        else if (t == INST_T_LH || t == INST_T_LHU || t == INST_T_SH) a[0] = 1'b0;
      end
      e = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      w = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      f = -1;
      if (r == 0) f = 0;
      else if (r < 3 && w >= 2) f = $urandom_range(1, w - 1);
      if ($urandom_range(0, 11) == 0) flushCycle($sformatf("rndFlush%0d", i));
      applyStimulus($sformatf("rnd%0d", i), t, a, $urandom, e, w, $urandom, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage core; consumes the EX/MEM pipeline register outputs and feeds the MEM/WB register and CP0 exception logic.
- Performs loads/stores over a req/ack data bus, with byte-lane steering and sign/zero extension.
- Owns the LL/SC link bit and detects address-alignment exceptions.
- Requests a pipeline stall while a bus access is outstanding.

Parameters:
- DW, 32, data/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush from ctrl (exception/eret)
- mem_gpr_we, mem_target_gpr[5], mem_exe_result[DW]  in  GPR write info from EX/MEM
- mem_hi, mem_lo [DW], mem_hilo_we  in  HI/LO write info
- mem_inst_type  in  8  instruction class (package codes)
- mem_dmem_addr  in  DW  effective address
- mem_ls_data_tmp  in  DW  store data (rt)
- mem_cp0_we, mem_cp0_waddr[5], mem_cp0_wdata[DW]  in  CP0 write info
- mem_except_type, mem_cur_inst_addr [DW], mem_inst_delayslot  in  exception info
- wb_gpr_we, wb_target_gpr, wb_gpr_wdata  out  to MEM/WB
- wb_hi, wb_lo, wb_hilo_we, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  out  pass-through to MEM/WB
- except_type_o, cur_inst_addr_o, inst_delayslot_o, bad_vaddr_o  out  to CP0/ctrl
- dbus_req, dbus_we  out  1  bus request / write
- dbus_addr  out  DW  word-aligned address
- dbus_sel  out  4  byte enables, bit3 = bits[31:24]
- dbus_wdata  out  DW  write data
- dbus_rdata  in  DW  read data, valid with ack
- dbus_ack  in  1  single-cycle completion
- stall_req  out  1  hold IF..MEM

Behaviour:
- Reset: state IDLE, llbit 0, rdata_q 0, dbus_req/we/sel/addr/wdata 0, stall_req 0.
- All wb_* outputs are combinational and equal to their inputs, gated to 0 when an exception is present.
- Byte order is big-endian. Offset o = addr[1:0].
- Alignment:
  - LH/LHU/SH require o[0]=0.
  - LW/SW/LL/SC require o=0.
  - A misaligned load sets except_type_o bit EXC_ADEL; a misaligned store sets bit EXC_ADES. Other bits pass through from mem_except_type.
  - bad_vaddr_o = mem_dmem_addr.
- Access valid (acc_v): inst is load/store, mem_except_type==0, no alignment error, and not (SC with llbit=0).
- Store lanes:
  - SB: sel = 4'b1000>>o; wdata = {4{rt[7:0]}}.
  - SH: sel = o[1] ? 0011 : 1100; wdata = {2{rt[15:0]}}.
  - SW/SC: sel = 1111.
- Loads: sel = 1111. Byte/half are extracted from the captured word, sign-extended for LB/LH and zero-extended for LBU/LHU.
- FSM (registered state; bus fields latched on the IDLE->WAIT transition):
  - IDLE: if acc_v and !flush, drive req from live inputs and stall_req=1.
    - ack same cycle: capture rdata -> DONE.
    - no ack: latch bus fields -> WAIT.
  - WAIT: hold req with latched fields; stall_req=1.
    - ack: capture -> DONE.
    - flush while waiting -> DRAIN.
  - DRAIN: hold req until ack, discard data; stall_req=1; -> IDLE on ack.
  - DONE: req=0, stall_req=0, wb_gpr_wdata from rdata_q; -> IDLE next cycle.
  - Minimum load/store latency is 2 cycles in MEM.
- Non-memory instructions never stall.
- An instruction with an exception issues no access, and wb_gpr_we=0.
- LL/SC:
  - LL sets llbit=1 in DONE.
  - SC with llbit=1 performs the store, returns wb_gpr_wdata=1 in DONE, and clears llbit.
  - SC with llbit=0 issues no access, wb_gpr_wdata=0, no stall.
- flush clears llbit (priority over the LL set in the same cycle).
- flush in IDLE or DONE -> IDLE, no request issued.
- rst mid-access: immediate IDLE; bus must tolerate a dropped req.

Decomposition:
- Shared package (defines file) holds:
  - INST_T_* codes: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
  - EXC_ADEL/EXC_ADES bit indices.
  - FSM state encodings.
- One sub-module, lsu_lane_align: combinational sel/wdata generation and load extraction/extension from (type, offset, word).

Test Plan:
- LB addr 0x1003, rdata 0x112233F4, ack after 2 waits -> stall_req high 3 cycles; DONE wb_gpr_wdata 0xFFFFFFF4, wb_gpr_we=1.
- SH addr 0x2002, rt 0x0000ABCD, ack same cycle -> dbus_sel 0011, dbus_wdata 0xABCDABCD, dbus_we=1; next cycle stall_req=0.
- LW addr 0x3001 -> no dbus_req, except_type_o EXC_ADEL set, wb_gpr_we=0, bad_vaddr_o 0x3001, no stall.
- LL 0x4000 then SC 0x4000 -> SC stores with sel 1111, result 1, llbit cleared; second SC -> no req, result 0.
- LL completes, flush, then SC -> no access, result 0.
- SW waiting for ack, flush asserted -> req held with the original addr/data until ack; stall_req stays high until ack, then IDLE with no writeback.
